// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the memory-stage stack controller.
//   - DEF_ADDR_W / DEF_SP_INIT / DEF_PC_W : default parameter values
//   - DATA_W / CCR_W                      : data-memory word and flag widths
//   - mem_state_e                         : stack-sequencer FSM states
//   - rd_tgt_e                            : where this cycle's read data lands
//   - ccr_word()                          : zero-extends flags to a memory word
package mem_stage_pkg;

    localparam int unsigned DEF_ADDR_W  = 11;
    localparam int unsigned DEF_SP_INIT = 2 ** DEF_ADDR_W - 1;
    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CCR_W       = 3;

    typedef enum logic [2:0] {
        StIdle,
        StPshPcLo,
        StPshCcr,
        StPopPcLo,
        StPopPcHi
    } mem_state_e;

    typedef enum logic [2:0] {
        RdNone,
        RdLoad,    // mem_read result into wb_data
        RdPop,     // plain pop result into wb_data
        RdCcr,     // lone CCR restore, pulse immediately
        RdCcrSeq,  // CCR popped ahead of a PC restore, held until PC completes
        RdPcLo,
        RdPcHi
    } rd_tgt_e;

    function automatic logic [DATA_W-1:0] ccr_word(input logic [CCR_W-1:0] ccr);
        return {{(DATA_W - CCR_W){1'b0}}, ccr};
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: stack pointer register with bounds-checked push/pop and a sticky fault flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : a push is requested this cycle (decrements SP when legal)
//   pop_i       : a pop is requested this cycle (increments SP when legal)
//   sp_o        : current SP (next free word)
//   sp_up_o     : SP + 1 (address of the top occupied word)
//   push_ok_o   : push requested and stack not full
//   pop_ok_o    : pop requested and stack not empty
//   fault_o     : sticky overflow/underflow flag
module stack_pointer
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned SP_INIT = 2 ** ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] sp_up_o,
    output logic              push_ok_o,
    output logic              pop_ok_o,
    output logic              fault_o
);

    localparam logic [ADDR_W-1:0] SpTop = ADDR_W'(SP_INIT);

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              fault_q, fault_d;
    logic              full, empty;

    assign full      = (sp_q == '0);
    assign empty     = (sp_q == SpTop);
    assign push_ok_o = push_i & ~full;
    assign pop_ok_o  = pop_i & ~empty;

    // A blocked boundary access leaves SP untouched, so SP never wraps.
    always_comb begin
        sp_d = sp_q;
        if (push_ok_o) begin
            sp_d = sp_q - ADDR_W'(1);
        end else if (pop_ok_o) begin
            sp_d = sp_q + ADDR_W'(1);
        end
    end

    assign fault_d = fault_q | (push_i & full) | (pop_i & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= SpTop;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    assign sp_o    = sp_q;
    assign sp_up_o = sp_q + ADDR_W'(1);
    assign fault_o = fault_q;

endmodule

// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: memory stage. Drives one data-memory port for loads, stores and stack
// transfers, sequences multi-word PC/CCR save/restore, and registers MEM/WB results.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   alu_result_i, rs_data_i       : load/store address and store data
//   rd_data_i, rd_i               : push data, destination register
//   mem_read_i .. pop_ccr_i       : EX/MEM control bits
//   pc_ret_i, ccr_in_i            : return PC and flags to save
//   mem_addr_o/wdata_o/we_o       : data-memory port (combinational)
//   mem_rdata_i                   : asynchronous read data for mem_addr_o
//   stall_o                       : hold upstream stages (combinational)
//   wb_data_o/wb_rd_o/wb_reg_write_o : registered write-back bundle
//   pc_restore_o/_valid_o         : restored PC and one-cycle pulse
//   ccr_restore_o/_valid_o        : restored flags and one-cycle pulse
//   sp_o, stack_fault_o           : stack pointer and sticky fault flag
module stack_mem_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned SP_INIT = 2 ** ADDR_W - 1,
    parameter int unsigned PC_W    = DEF_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [2:0]        rd_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              push_pc_i,
    input  logic              pop_pc_i,
    input  logic              push_ccr_i,
    input  logic              pop_ccr_i,
    input  logic [PC_W-1:0]   pc_ret_i,
    input  logic [CCR_W-1:0]  ccr_in_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [2:0]        wb_rd_o,
    output logic              wb_reg_write_o,
    output logic [PC_W-1:0]   pc_restore_o,
    output logic              pc_restore_valid_o,
    output logic [CCR_W-1:0]  ccr_restore_o,
    output logic              ccr_restore_valid_o,
    output logic [ADDR_W-1:0] sp_o,
    output logic              stack_fault_o
);

    mem_state_e        state_q, state_d;
    rd_tgt_e           rd_tgt;
    logic              stk_push, stk_pop, push_ok, pop_ok;
    logic              wr_req, stall_c;
    logic [ADDR_W-1:0] sp, sp_up, addr;
    logic [DATA_W-1:0] wdata, pop_data;

    logic [DATA_W-1:0] wb_data_q;
    logic [2:0]        wb_rd_q;
    logic              wb_reg_write_q;
    logic [PC_W-1:0]   pc_restore_q;
    logic              pc_restore_valid_q;
    logic [CCR_W-1:0]  ccr_restore_q;
    logic              ccr_restore_valid_q;
    logic [DATA_W-1:0] pc_lo_q;
    logic [CCR_W-1:0]  ccr_hold_q;
    logic              ccr_pend_q;

    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_result_i[DATA_W-1:ADDR_W];

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_stack_pointer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .sp_o      (sp),
        .sp_up_o   (sp_up),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok),
        .fault_o   (stack_fault_o)
    );

    // Decode the current step: which stack op, which address/data, where read data goes.
    always_comb begin
        state_d  = state_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        wr_req   = 1'b0;
        stall_c  = 1'b0;
        rd_tgt   = RdNone;
        addr     = alu_result_i[ADDR_W-1:0];
        wdata    = rs_data_i;
        unique case (state_q)
            StIdle: begin
                if (pop_ccr_i || pop_pc_i) begin
                    stk_pop = 1'b1;
                    addr    = sp_up;
                    if (pop_pc_i) begin
                        // CCR sits above the PC, so with both set the first word is CCR.
                        stall_c = 1'b1;
                        rd_tgt  = pop_ccr_i ? RdCcrSeq : RdPcLo;
                        state_d = pop_ccr_i ? StPopPcLo : StPopPcHi;
                    end else begin
                        rd_tgt = RdCcr;
                    end
                end else if (push_pc_i || push_ccr_i) begin
                    stk_push = 1'b1;
                    addr     = sp;
                    if (push_pc_i) begin
                        wdata   = pc_ret_i[PC_W-1:DATA_W];
                        stall_c = 1'b1;
                        state_d = StPshPcLo;
                    end else begin
                        wdata = ccr_word(ccr_in_i);
                    end
                end else if (push_i) begin
                    stk_push = 1'b1;
                    addr     = sp;
                    wdata    = rd_data_i;
                end else if (pop_i) begin
                    stk_pop = 1'b1;
                    addr    = sp_up;
                    rd_tgt  = RdPop;
                end else if (mem_write_i) begin
                    wr_req = 1'b1;
                end else if (mem_read_i) begin
                    rd_tgt = RdLoad;
                end
            end
            StPshPcLo: begin
                stk_push = 1'b1;
                addr     = sp;
                wdata    = pc_ret_i[DATA_W-1:0];
                if (push_ccr_i) begin
                    stall_c = 1'b1;
                    state_d = StPshCcr;
                end else begin
                    state_d = StIdle;
                end
            end
            StPshCcr: begin
                stk_push = 1'b1;
                addr     = sp;
                wdata    = ccr_word(ccr_in_i);
                state_d  = StIdle;
            end
            StPopPcLo: begin
                stk_pop = 1'b1;
                addr    = sp_up;
                rd_tgt  = RdPcLo;
                stall_c = 1'b1;
                state_d = StPopPcHi;
            end
            StPopPcHi: begin
                stk_pop = 1'b1;
                addr    = sp_up;
                rd_tgt  = RdPcHi;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // An underflowing pop yields zero rather than whatever wrapped address was read.
    assign pop_data = pop_ok ? mem_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= StIdle;
            wb_data_q           <= '0;
            wb_rd_q             <= '0;
            wb_reg_write_q      <= 1'b0;
            pc_restore_q        <= '0;
            pc_restore_valid_q  <= 1'b0;
            ccr_restore_q       <= '0;
            ccr_restore_valid_q <= 1'b0;
            pc_lo_q             <= '0;
            ccr_hold_q          <= '0;
            ccr_pend_q          <= 1'b0;
        end else begin
            state_q             <= state_d;
            wb_rd_q             <= stall_c ? 3'd0 : rd_i;
            wb_reg_write_q      <= ~stall_c & reg_write_i;
            pc_restore_valid_q  <= 1'b0;
            ccr_restore_valid_q <= 1'b0;
            case (rd_tgt)
                RdLoad: wb_data_q <= mem_rdata_i;
                RdPop:  wb_data_q <= pop_data;
                RdCcr: begin
                    ccr_restore_q       <= pop_data[CCR_W-1:0];
                    ccr_restore_valid_q <= 1'b1;
                end
                RdCcrSeq: begin
                    ccr_hold_q <= pop_data[CCR_W-1:0];
                    ccr_pend_q <= 1'b1;
                end
                RdPcLo: pc_lo_q <= pop_data;
                RdPcHi: begin
                    pc_restore_q       <= {pop_data, pc_lo_q};
                    pc_restore_valid_q <= 1'b1;
                    // A CCR popped with the PC is released together with it.
                    if (ccr_pend_q) begin
                        ccr_restore_q       <= ccr_hold_q;
                        ccr_restore_valid_q <= 1'b1;
                    end
                    ccr_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Gate with reset so nothing is written or stalled while reset is held.
    assign mem_addr_o          = addr;
    assign mem_wdata_o         = wdata;
    assign mem_we_o            = rst_n & (wr_req | push_ok);
    assign stall_o             = rst_n & stall_c;
    assign wb_data_o           = wb_data_q;
    assign wb_rd_o             = wb_rd_q;
    assign wb_reg_write_o      = wb_reg_write_q;
    assign pc_restore_o        = pc_restore_q;
    assign pc_restore_valid_o  = pc_restore_valid_q;
    assign ccr_restore_o       = ccr_restore_q;
    assign ccr_restore_valid_o = ccr_restore_valid_q;
    assign sp_o                = sp;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb_stack_mem_ctrl: self-checking bench for stack_mem_ctrl with a behavioural data memory
// and a queue-based stack model.
module tb_stack_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] alu_result, rs_data, rd_data, mem_wdata, mem_rdata, wb_data;
    logic [2:0]  rd, ccr_in, wb_rd, ccr_restore;
    logic        mem_read, mem_write, reg_write, push, pop, push_pc, pop_pc, push_ccr, pop_ccr;
    logic [31:0] pc_ret, pc_restore;
    logic [10:0] mem_addr, sp;
    logic        mem_we, stall, wb_reg_write, pc_restore_valid, ccr_restore_valid, stack_fault;

    logic [15:0] mem [0:2047];
    int n_checks = 0;
    int n_fail   = 0;

    stack_mem_ctrl u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu_result_i        (alu_result),
        .rs_data_i           (rs_data),
        .rd_data_i           (rd_data),
        .rd_i                (rd),
        .mem_read_i          (mem_read),
        .mem_write_i         (mem_write),
        .reg_write_i         (reg_write),
        .push_i              (push),
        .pop_i               (pop),
        .push_pc_i           (push_pc),
        .pop_pc_i            (pop_pc),
        .push_ccr_i          (push_ccr),
        .pop_ccr_i           (pop_ccr),
        .pc_ret_i            (pc_ret),
        .ccr_in_i            (ccr_in),
        .mem_addr_o          (mem_addr),
        .mem_wdata_o         (mem_wdata),
        .mem_we_o            (mem_we),
        .mem_rdata_i         (mem_rdata),
        .stall_o             (stall),
        .wb_data_o           (wb_data),
        .wb_rd_o             (wb_rd),
        .wb_reg_write_o      (wb_reg_write),
        .pc_restore_o        (pc_restore),
        .pc_restore_valid_o  (pc_restore_valid),
        .ccr_restore_o       (ccr_restore),
        .ccr_restore_valid_o (ccr_restore_valid),
        .sp_o                (sp),
        .stack_fault_o       (stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {mem_read, mem_write, reg_write, push, pop, push_pc, pop_pc, push_ccr, pop_ccr} = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Hold current inputs until stall drops; sample each cycle before the edge.
    task automatic run_seq(output int nst, output bit done, output int early, output int wb_bad);
        bit st;
        nst = 0; done = 1'b0; early = 0; wb_bad = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            st = stall;
            if (st) nst++; else done = 1'b1;
            if (pc_restore_valid || ccr_restore_valid) early++;
            tick();
            if (wb_reg_write !== (!st && reg_write)) wb_bad++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        push = 1'b1; push_pc = 1'b1; rd_data = 16'h1111;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({sp, stack_fault, stall, mem_we} !== {11'd2047, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_sp_flags: got sp=%0d flt=%b stall=%b we=%b want 2047 0 0 0",
                     sp, stack_fault, stall, mem_we);
        end
        n_checks++;
        if ({wb_data, wb_rd, wb_reg_write, pc_restore, pc_restore_valid, ccr_restore,
             ccr_restore_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got wb=%h rd=%0d rw=%b pc=%h pv=%b cc=%b cv=%b want all 0",
                     wb_data, wb_rd, wb_reg_write, pc_restore, pc_restore_valid, ccr_restore,
                     ccr_restore_valid);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_push_pop();
        do_reset();
        rd_data = 16'hBEEF; push = 1'b1;
        #1;
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'd2047, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL push_port: got we=%b a=%0d d=%h want 1 2047 beef", mem_we, mem_addr,
                     mem_wdata);
        end
        tick();
        push = 1'b0;
        n_checks++;
        if ({sp, mem[2047]} !== {11'd2046, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL push_result: got sp=%0d m=%h want 2046 beef", sp, mem[2047]);
        end
        pop = 1'b1; rd = 3'd3; reg_write = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if ({wb_data, wb_rd, wb_reg_write, sp} !== {16'hBEEF, 3'd3, 1'b1, 11'd2047}) begin
            n_fail++;
            $display("FAIL pop_result: got wb=%h rd=%0d rw=%b sp=%0d want beef 3 1 2047",
                     wb_data, wb_rd, wb_reg_write, sp);
        end
    endtask

    task automatic test_pc_ccr();
        int nst, early, wbb;
        bit done;
        do_reset();
        pc_ret = 32'h1234_5678; ccr_in = 3'b101; push_pc = 1'b1; push_ccr = 1'b1;
        reg_write = 1'b1; rd = 3'd6;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 2 || wbb != 0) begin
            n_fail++;
            $display("FAIL push_pc_ccr_stall: got done=%b stalls=%0d wbbad=%0d want 1 2 0",
                     done, nst, wbb);
        end
        n_checks++;
        if ({mem[2047], mem[2046], mem[2045], sp} !== {16'h1234, 16'h5678, 16'h0005, 11'd2044})
        begin
            n_fail++;
            $display("FAIL push_pc_ccr_mem: got %h %h %h sp=%0d want 1234 5678 0005 2044",
                     mem[2047], mem[2046], mem[2045], sp);
        end
        pop_pc = 1'b1; pop_ccr = 1'b1; reg_write = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 2 || early != 0 || wbb != 0) begin
            n_fail++;
            $display("FAIL pop_pc_ccr_stall: got done=%b stalls=%0d early=%0d wbbad=%0d want 1 2 0 0",
                     done, nst, early, wbb);
        end
        n_checks++;
        if ({pc_restore_valid, pc_restore, ccr_restore_valid, ccr_restore, sp} !==
            {1'b1, 32'h1234_5678, 1'b1, 3'b101, 11'd2047}) begin
            n_fail++;
            $display("FAIL pop_pc_ccr_vals: got pv=%b pc=%h cv=%b cc=%b sp=%0d want 1 12345678 1 101 2047",
                     pc_restore_valid, pc_restore, ccr_restore_valid, ccr_restore, sp);
        end
        tick();
        n_checks++;
        if ({pc_restore_valid, ccr_restore_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL pop_pc_ccr_pulse: got pv=%b cv=%b want 0 0", pc_restore_valid,
                     ccr_restore_valid);
        end
    endtask

    task automatic test_single_ops();
        logic [31:0] pc;
        logic [2:0]  cc;
        int nst, early, wbb;
        bit done;
        do_reset();
        pc = $urandom; pc_ret = pc; push_pc = 1'b1; reg_write = 1'b1; rd = 3'd2;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 1 || wbb != 0 || {mem[2047], mem[2046], sp} !== {pc, 11'd2045}) begin
            n_fail++;
            $display("FAIL push_pc_only: got stalls=%0d m=%h%h sp=%0d want 1 %h 2045",
                     nst, mem[2047], mem[2046], sp, pc);
        end
        pop_pc = 1'b1; reg_write = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 1 || early != 0 || wbb != 0 ||
            {pc_restore_valid, pc_restore, ccr_restore_valid, sp} !== {1'b1, pc, 1'b0, 11'd2047})
        begin
            n_fail++;
            $display("FAIL pop_pc_only: got stalls=%0d pv=%b pc=%h cv=%b sp=%0d want 1 1 %h 0 2047",
                     nst, pc_restore_valid, pc_restore, ccr_restore_valid, sp, pc);
        end
        cc = 3'($urandom); ccr_in = cc; push_ccr = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 0 || {mem[2047], sp} !== {13'd0, cc, 11'd2046}) begin
            n_fail++;
            $display("FAIL push_ccr_only: got stalls=%0d m=%h sp=%0d want 0 %h 2046",
                     nst, mem[2047], sp, cc);
        end
        pop_ccr = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 0 ||
            {ccr_restore_valid, ccr_restore, pc_restore_valid, sp} !== {1'b1, cc, 1'b0, 11'd2047})
        begin
            n_fail++;
            $display("FAIL pop_ccr_only: got stalls=%0d cv=%b cc=%b pv=%b sp=%0d want 0 1 %b 0 2047",
                     nst, ccr_restore_valid, ccr_restore, pc_restore_valid, sp, cc);
        end
    endtask

    task automatic test_mem_rw();
        logic [10:0] a;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 11'h010 : 11'($urandom_range(0, 1500));
            d = (i == 0) ? 16'hA5A5 : 16'($urandom);
            alu_result = {5'($urandom), a}; rs_data = d; mem_write = 1'b1;
            #1;
            n_checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a, d}) begin
                n_fail++;
                $display("FAIL store_port: got we=%b a=%h d=%h want 1 %h %h", mem_we, mem_addr,
                         mem_wdata, a, d);
            end
            tick();
            mem_write = 1'b0; mem_read = 1'b1; rs_data = ~d;
            tick();
            mem_read = 1'b0;
            n_checks++;
            if ({wb_data, sp} !== {d, 11'd2047}) begin
                n_fail++;
                $display("FAIL load_data: got wb=%h sp=%0d want %h 2047", wb_data, sp, d);
            end
        end
    endtask

    // Random push/pop/load/store mix against a queue stack and an address-indexed shadow.
    task automatic test_random();
        logic [15:0] model[$];
        logic [15:0] shadow[64];
        bit          written[64];
        logic [15:0] d, exp;
        logic [5:0]  a;
        logic [2:0]  r;
        int          op;
        do_reset();
        for (int i = 0; i < 64; i++) written[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 3);
            a  = 6'($urandom);
            d  = 16'($urandom);
            r  = 3'($urandom);
            if (op == 1 && model.size() == 0) op = 0;
            if (op == 0 && model.size() >= 200) op = 1;
            if (op == 3 && !written[a]) op = 2;
            idle_inputs();
            alu_result = {10'd0, a}; rs_data = d; rd_data = d; rd = r;
            if (op == 0) begin
                push = 1'b1; pop = 1'($urandom); mem_write = 1'($urandom);
                mem_read = 1'($urandom);
                tick();
                model.push_back(d);
                n_checks++;
                if (sp !== 11'(2047 - model.size()) || mem[2048 - model.size()] !== d) begin
                    n_fail++;
                    $display("FAIL rnd_push: got sp=%0d m=%h want %0d %h", sp,
                             mem[2048 - model.size()], 2047 - model.size(), d);
                end
            end else if (op == 1) begin
                pop = 1'b1; reg_write = 1'b1; mem_write = 1'($urandom); mem_read = 1'($urandom);
                tick();
                exp = model.pop_back();
                n_checks++;
                if ({wb_data, wb_rd, sp} !== {exp, r, 11'(2047 - model.size())}) begin
                    n_fail++;
                    $display("FAIL rnd_pop: got wb=%h rd=%0d sp=%0d want %h %0d %0d", wb_data,
                             wb_rd, sp, exp, r, 2047 - model.size());
                end
            end else if (op == 2) begin
                mem_write = 1'b1; mem_read = 1'($urandom);
                tick();
                shadow[a] = d; written[a] = 1'b1;
                n_checks++;
                if (mem[a] !== d) begin
                    n_fail++;
                    $display("FAIL rnd_store: got %h want %h at %0d", mem[a], d, a);
                end
            end else begin
                mem_read = 1'b1;
                tick();
                n_checks++;
                if (wb_data !== shadow[a]) begin
                    n_fail++;
                    $display("FAIL rnd_load: got %h want %h at %0d", wb_data, shadow[a], a);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_fault();
        int nst, early, wbb;
        bit done;
        logic [15:0] m0;
        do_reset();
        pop = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_we: got %b want 0", mem_we);
        end
        tick();
        pop = 1'b0;
        n_checks++;
        if ({stack_fault, sp} !== {1'b1, 11'd2047}) begin
            n_fail++;
            $display("FAIL underflow: got flt=%b sp=%0d want 1 2047", stack_fault, sp);
        end
        pop_pc = 1'b1; pop_ccr = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        n_checks++;
        if (!done || nst != 2 || {pc_restore_valid, pc_restore, ccr_restore, stack_fault, sp} !==
            {1'b1, 32'd0, 3'd0, 1'b1, 11'd2047}) begin
            n_fail++;
            $display("FAIL underflow_pc: got stalls=%0d pv=%b pc=%h cc=%b flt=%b sp=%0d want 2 1 0 0 1 2047",
                     nst, pc_restore_valid, pc_restore, ccr_restore, stack_fault, sp);
        end
        do_reset();
        push = 1'b1;
        for (int i = 0; i < 2047; i++) begin
            rd_data = 16'(i);
            tick();
        end
        n_checks++;
        if ({sp, stack_fault, mem[1]} !== {11'd0, 1'b0, 16'd2046}) begin
            n_fail++;
            $display("FAIL fill: got sp=%0d flt=%b m1=%h want 0 0 07fe", sp, stack_fault, mem[1]);
        end
        m0 = mem[0];
        rd_data = ~m0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_we: got %b want 0", mem_we);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({sp, stack_fault, mem[0]} !== {11'd0, 1'b1, m0}) begin
            n_fail++;
            $display("FAIL overflow: got sp=%0d flt=%b m0=%h want 0 1 %h", sp, stack_fault,
                     mem[0], m0);
        end
    endtask

    task automatic test_reset_mid();
        int nst, early, wbb, pulses;
        bit done;
        do_reset();
        pc_ret = $urandom; ccr_in = 3'($urandom); push_pc = 1'b1; push_ccr = 1'b1;
        run_seq(nst, done, early, wbb);
        idle_inputs();
        pop_pc = 1'b1; pop_ccr = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({stall, sp} !== {1'b1, 11'd2045}) begin
            n_fail++;
            $display("FAIL mid_seq_state: got stall=%b sp=%0d want 1 2045", stall, sp);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stall, sp} !== {1'b0, 11'd2047}) begin
            n_fail++;
            $display("FAIL mid_reset: got stall=%b sp=%0d want 0 2047", stall, sp);
        end
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_restore_valid || ccr_restore_valid || stall) pulses++;
        end
        n_checks++;
        if (pulses != 0 || {sp, pc_restore} !== {11'd2047, 32'd0}) begin
            n_fail++;
            $display("FAIL post_reset: got stray=%0d sp=%0d pc=%h want 0 2047 0", pulses, sp,
                     pc_restore);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        alu_result = '0; rs_data = '0; rd_data = '0; rd = '0; pc_ret = '0; ccr_in = '0;
        test_reset();
        test_push_pop();
        test_pc_ccr();
        test_single_ops();
        test_mem_rw();
        test_random();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
- Memory-stage consumer of the EX/MEM bundle. Takes ALU_result, Rs/Rd data, Rd, memRead/memWrite/regWrite, push/pop, pushPc/popPc and pushCCR/popCCR.
- Owns the stack pointer and sequences single-cycle and multi-word stack transfers onto one data-memory port.
- Registers results for the MEM/WB boundary.
- Stalls upstream while a multi-word PC/CCR save or restore is in progress.

Parameters:
- ADDR_W, 11, data-memory word-address width.
- SP_INIT, 2**ADDR_W-1, stack pointer reset value (empty stack, top of memory).
- PC_W, 32, return-PC width; always two 16-bit words.

Ports:
- clk  in  1  clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- alu_result  in  16  load/store address; low ADDR_W bits used.
- rs_data  in  16  store data.
- rd_data  in  16  push data.
- rd  in  3  destination register.
- mem_read, mem_write, reg_write, push, pop, push_pc, pop_pc, push_ccr, pop_ccr  in  1 each  control bits from EX/MEM.
- pc_ret  in  32  return PC to save.
- ccr_in  in  3  flags to save.
- mem_addr  out  ADDR_W  data-memory address (combinational).
- mem_wdata  out  16  write data (combinational).
- mem_we  out  1  write enable (combinational).
- mem_rdata  in  16  asynchronous read data for mem_addr.
- stall  out  1  hold EX/MEM and earlier stages (combinational).
- wb_data  out  16  registered load/pop result.
- wb_rd  out  3  registered destination.
- wb_reg_write  out  1  registered write-back enable.
- pc_restore  out  32  registered restored PC.
- pc_restore_valid  out  1  one-cycle pulse.
- ccr_restore  out  3  registered restored flags.
- ccr_restore_valid  out  1  one-cycle pulse.
- sp  out  ADDR_W  current stack pointer.
- stack_fault  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - sp=SP_INIT, state=IDLE, stack_fault=0.
  - All registered outputs 0; mem_we=0.
- Stack discipline: SP points to the next free word.
  - Push: write mem[SP], then SP-1.
  - Pop: SP+1, then read mem[SP+1].
- Priority in IDLE: pop_ccr/pop_pc > push_pc/push_ccr > push > pop > mem_write > mem_read. Lower-priority bits are ignored that cycle.
- Single-cycle ops (IDLE, stall=0):
  - mem_read: addr=alu_result. Next edge: wb_data=mem_rdata.
  - mem_write: addr=alu_result, wdata=rs_data, we=1.
  - push: addr=SP, wdata=rd_data, we=1, SP--.
  - pop: addr=SP+1, SP++. Next edge: wb_data=mem_rdata.
  - push_ccr alone: wdata={13'b0,ccr_in}, SP--.
  - pop_ccr alone: SP++. Next edge: ccr_restore=rdata[2:0], ccr_restore_valid=1.
- wb_rd/wb_reg_write register rd/reg_write every non-stalled cycle. They are 0 while stall=1.
- FSM states: IDLE, PSH_PC_LO, PSH_CCR, POP_PC_LO, POP_PC_HI.
- push_pc (IDLE):
  - Write pc_ret[31:16] at SP, SP--, stall=1 → PSH_PC_LO.
  - PSH_PC_LO: write pc_ret[15:0], SP--. If push_ccr → PSH_CCR (stall=1); else → IDLE (stall=0).
  - PSH_CCR: write ccr, SP--, stall=0 → IDLE.
- pop_ccr with pop_pc (IDLE):
  - Read CCR at SP+1, SP++, stall=1 → POP_PC_LO.
  - pop_pc alone goes directly to POP_PC_LO reading, i.e. IDLE performs the LO read.
  - POP_PC_LO: read low word, SP++, stall=1 → POP_PC_HI.
  - POP_PC_HI: read high word, SP++, stall=0 → IDLE.
  - Next edge after POP_PC_HI: pc_restore={hi,lo}, pc_restore_valid=1. The ccr_restore pulse is emitted in the same cycle.
- Inputs are held stable by upstream while stall=1. The block samples push_ccr/pop_ccr again in later states.
- Stack fault:
  - Overflow: push of any kind with SP==0.
  - Underflow: pop of any kind with SP==SP_INIT.
  - Response: we=0, SP unchanged, stack_fault←1 (sticky until reset). The sequence still advances so the pipeline never hangs; restored values are 0.
- SP arithmetic is ADDR_W-bit. No wrap occurs because faults block the boundary.
- rst_n low mid-sequence: immediate IDLE, stall=0, pulses cleared.

Decomposition:
- Shared package `mem_stage_pkg`: state enum, ADDR_W/SP_INIT/PC_W defaults, CCR_W=3.
- One sub-module is natural: `stack_pointer` (SP register with inc/dec, empty/full compares, fault generation).
- The FSM and output registers stay in the top.

Test Plan:
- Reset, then push rd_data=16'hBEEF → mem[2047]=BEEF, sp=2046; then pop rd=3 → next cycle wb_data=BEEF, wb_rd=3, sp=2047.
- push_pc+push_ccr, pc_ret=32'h1234_5678, ccr=3'b101 → stall high 2 cycles; mem[2047]=1234, mem[2046]=5678, mem[2045]=0005, sp=2044.
- Then pop_pc+pop_ccr → stall 2 cycles; then pc_restore=12345678, ccr_restore=101, both valid pulses 1 cycle; sp=2047.
- mem_write alu_result=16'h0010, rs_data=16'hA5A5; then mem_read same address → wb_data=A5A5, sp unchanged.
- pop at SP_INIT → stack_fault=1, sp=2047, mem_we=0. Drive 2047 pushes, then one more → stack_fault remains 1, sp=0.
- Assert rst_n=0 during POP_PC_LO → stall=0, sp=2047, pc_restore_valid never pulses.
